uart_decimal_receiver: RTL and testbench
========================================

// Module: uart_decimal_receiver
// PURPOSE
//   Receives 8N1 UART bytes on RxD and parses ASCII decimal numbers of up to
//   MAX_DIGITS digits, each terminated by TAB, CR or LF, into a 16-bit binary value.
//   It is the host-to-FPGA counterpart of the decimal-ASCII UART transmit path.
//   It delivers setpoints and commands from the PC into the power-quality core
//   as a one-cycle valid strobe with a held value.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency in Hz
//   BAUD        9600         line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division)
//   MAX_DIGITS  5            maximum digits accepted per number
// PORTS
//   clk    in   1   system clock; all logic on rising edge
//   rst_n  in   1   asynchronous active-low reset
//   RxD    in   1   UART serial input; idles high
//   val    out  16  last successfully parsed value; held until the next success
//   valid  out  1   one-cycle pulse; val updated on the same edge
//   err    out  1   one-cycle pulse on any parse or framing error
//   busy   out  1   high while a byte frame is in progress (START..STOP)
// BEHAVIOUR
//   Reset: val=0, valid=0, err=0, busy=0; FSM to IDLE; accumulator, digit count and
//     poison flag cleared. Reset mid-frame or mid-number aborts both; nothing is emitted.
//   RxD passes through a 2-FF synchronizer before any use.
//   Byte FSM, counter bit_cnt in 0..CLKS_PER_BIT-1:
//     IDLE : on a synchronized falling edge -> START, counter cleared.
//     START: at CLKS_PER_BIT/2, sample the line; low -> DATA; high -> IDLE (glitch).
//     DATA : sample every CLKS_PER_BIT at bit centre; 8 bits, LSB first -> STOP.
//     STOP : sample at centre; high -> byte_done pulse; low -> frame_err pulse.
//       Either case -> IDLE. A new start bit is accepted from the next cycle.
//   Parser acts on the edge after byte_done or frame_err:
//     digit 0x30-0x39: acc <= acc*10 + (b-0x30), computed as (acc<<3)+(acc<<1)+d
//       in 17 bits; digit count incremented.
//     0x20 (space): ignored; accumulator and count unchanged.
//     terminator 0x09/0x0D/0x0A:
//       count==0 and not poisoned -> ignored (CR LF yields only one value).
//       poisoned -> clear only.
//       otherwise, if acc<=65535 -> val<=acc[15:0] and valid=1; else err=1.
//       Always clear acc, count and poison.
//     any other byte, count reaching MAX_DIGITS+1, or frame_err: err=1, set poison.
//       While poisoned, no further err pulses occur until a terminator is received.
//   Latency: valid/err rise one clk after the stop-bit sample of the deciding byte.
//   valid and err are never high in the same cycle.
// CONFIGURATION
//   UART_DEC_SAT_EN defined: a terminated number greater than 65535 gives
//     valid=1, val=16'hFFFF and no err.
//     Digit-count overflow and illegal characters still raise err.
//   UART_DEC_SAT_EN undefined: a number greater than 65535 gives err=1,
//     no valid, and val unchanged.
// TESTING
//   Use CLK_FREQ=1_600_000 and BAUD=100_000, giving CLKS_PER_BIT=16.
//   1. "12345\t" -> single valid, val=16'h3039; err never asserted.
//   2. "65535\r\n" -> exactly one valid, val=16'hFFFF; LF produces nothing.
//   3. "65536\t" -> err pulse, val unchanged.
//      With UART_DEC_SAT_EN: valid, val=16'hFFFF.
//   4. "12a4\t" then "7\t" -> one err at 'a', no valid for the first number;
//      then valid with val=7.
//   5. "3" sent with stop bit forced low -> err.
//      A 4-clk low glitch on an idle line -> no byte, busy drops within 9 clks.
//   6. rst_n pulsed low in the middle of the '2' bits of "123", then "9\t"
//      -> outputs are at reset values during reset; then valid with val=9.
//   7. "123456\t" -> err on the 6th digit; the terminator emits nothing further.

Source files
------------

// File: rtl/uart_decimal_receiver.sv
`default_nettype none
// ============================================================================
// Module  : uart_decimal_receiver
// Brief   : 8N1 UART receiver that parses TAB/CR/LF-terminated ASCII decimal
//           numbers into a 16-bit value. Optional macro UART_DEC_SAT_EN
//           saturates oversize numbers to 16'hFFFF instead of flagging err.
// Revision: 1.0 - initial release
// ============================================================================
module uart_decimal_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int MAX_DIGITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RxD,
    output logic [15:0] val,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam int DW = $clog2(MAX_DIGITS + 2);
    localparam logic [DW-1:0] DIG_MAX = DW'(MAX_DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_done_q, byte_done_d;
    logic            frame_err_q, frame_err_d;
    logic [16:0]     acc_q, acc_d;
    logic [DW-1:0]   dig_cnt_q, dig_cnt_d;
    logic            poison_q, poison_d;
    logic [15:0]     val_q, val_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;

    logic w_is_digit, w_is_space, w_is_term;

    assign w_is_digit = (shift_q >= 8'h30) && (shift_q <= 8'h39);
    assign w_is_space = (shift_q == 8'h20);
    assign w_is_term  = (shift_q == 8'h09) || (shift_q == 8'h0D) || (shift_q == 8'h0A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            acc_q       <= '0;
            dig_cnt_q   <= '0;
            poison_q    <= 1'b0;
            val_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rx_meta_q   <= RxD;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
            acc_q       <= acc_d;
            dig_cnt_q   <= dig_cnt_d;
            poison_q    <= poison_d;
            val_q       <= val_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Byte framer: all samples are taken from the synchronized line.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (bit_cnt_q == HALF_BIT) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_TICK) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_cnt_q == LAST_TICK) begin
                    bit_cnt_d   = '0;
                    byte_done_d = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                    state_d     = S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Number parser: poison suppresses repeat errors until a terminator resyncs.
    always_comb begin
        acc_d     = acc_q;
        dig_cnt_d = dig_cnt_q;
        poison_d  = poison_q;
        val_d     = val_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (frame_err_q) begin
            err_d    = !poison_q;
            poison_d = 1'b1;
        end else if (byte_done_q) begin
            if (w_is_digit) begin
                if (!poison_q) begin
                    if (dig_cnt_q == DIG_MAX) begin
                        err_d    = 1'b1;
                        poison_d = 1'b1;
                    end else begin
                        acc_d     = (acc_q << 3) + (acc_q << 1) + {13'd0, shift_q[3:0]};
                        dig_cnt_d = dig_cnt_q + 1'b1;
                    end
                end
            end else if (w_is_space) begin
                acc_d = acc_q;
            end else if (w_is_term) begin
                if (!poison_q && (dig_cnt_q != '0)) begin
                    if (acc_q <= 17'd65535) begin
                        val_d   = acc_q[15:0];
                        valid_d = 1'b1;
                    end else begin
`ifdef UART_DEC_SAT_EN
                        val_d   = 16'hFFFF;
                        valid_d = 1'b1;
`else
                        err_d   = 1'b1;
`endif
                    end
                end
                acc_d     = '0;
                dig_cnt_d = '0;
                poison_d  = 1'b0;
            end else begin
                err_d    = !poison_q;
                poison_d = 1'b1;
            end
        end
    end

    assign val   = val_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_decimal_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_decimal_receiver
// Brief   : Directed scoreboard bench for uart_decimal_receiver (16 clks/bit).
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_decimal_receiver;

    localparam int CPB = 16;

    logic        clk;
    logic        rst_n;
    logic        RxD;
    logic [15:0] val;
    logic        valid;
    logic        err;
    logic        busy;

    typedef struct packed {
        logic        is_err;
        logic [15:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_val;
    int          errors;
    int          checks;

    uart_decimal_receiver #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .MAX_DIGITS(5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .RxD  (RxD),
        .val  (val),
        .valid(valid),
        .err  (err),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_valid(input logic [15:0] v);
        exp_q.push_back('{is_err: 1'b0, v: v});
        exp_val = v;
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, v: exp_val});
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (valid || err)) begin
                checks++;
                if (valid && err) begin
                    errors++;
                    $display("FAIL both_high actual valid=1 err=1 required=exclusive");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event actual valid=%0b err=%0b val=%h required=none",
                             valid, err, val);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err != err || e.v !== val) begin
                        errors++;
                        $display("FAIL event actual err=%0b val=%h required err=%0b val=%h",
                                 err, val, e.is_err, e.v);
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
        end
    endtask

    initial begin
        int  drop;
        bit  seen;
        errors  = 0;
        checks  = 0;
        exp_val = 16'h0000;
        rst_n   = 1'b0;
        RxD     = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("reset_val",   val,           16'h0000);
        check("reset_valid", {15'd0, valid}, 16'h0000);
        check("reset_err",   {15'd0, err},   16'h0000);
        check("reset_busy",  {15'd0, busy},  16'h0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        expect_valid(16'h3039);
        send_str("12345\t");

        expect_valid(16'hFFFF);
        send_str("65535\r\n");

`ifdef UART_DEC_SAT_EN
        expect_valid(16'hFFFF);
`else
        expect_err();
`endif
        send_str("65536\t");

        expect_err();
        send_str("12a4\t");
        expect_valid(16'h0007);
        send_str("7\t");

        expect_err();
        send_byte(8'h33, 1'b0);
        repeat (CPB) @(negedge clk);
        send_str("\t");

        // Short low glitch on an idle line must not start a byte.
        RxD = 1'b0;
        repeat (4) @(negedge clk);
        RxD  = 1'b1;
        seen = 1'b0;
        drop = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            if (seen && !busy && drop == 0) drop = i;
        end
        check("glitch_busy_seen", {15'd0, seen}, 16'h0001);
        check("glitch_busy_drop", {15'd0, (drop != 0 && drop <= 9)}, 16'h0001);
        repeat (CPB) @(negedge clk);

        send_byte(8'h31, 1'b1);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        RxD = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("midframe_busy", {15'd0, busy}, 16'h0001);
        rst_n = 1'b0;
        RxD   = 1'b1;
        @(negedge clk);
        check("midreset_val",   val,            16'h0000);
        check("midreset_valid", {15'd0, valid}, 16'h0000);
        check("midreset_err",   {15'd0, err},   16'h0000);
        check("midreset_busy",  {15'd0, busy},  16'h0000);
        exp_val = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_valid(16'h0009);
        send_str("9\t");

        expect_err();
        send_str("123456\t");

        repeat (40) @(negedge clk);
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
